// File: rtl/memory_bridge.sv
// Turns one-shot read/write strobes into a single valid/ready bus transaction; strobe to done is 2 cycles plus wait states.
// Holds bus fields stable until bus_ready; strobes are ignored while busy; optional timeout aborts with access_fault.
module memory_bridge #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int COUNTER_WIDTH  = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        read_request,
  input  logic        write_request,
  input  logic [31:0] read_memory_address,
  input  logic [31:0] write_memory_address,
  input  logic [31:0] write_memory_data,
  input  logic [31:0] write_memory_mask,
  output logic [31:0] read_memory_data,
  output logic        memory_busy,
  output logic        memory_done,
  output logic        access_fault,
  output logic        bus_valid,
  output logic        bus_write,
  output logic [31:0] bus_address,
  output logic [31:0] bus_write_data,
  output logic [3:0]  bus_byte_enable,
  input  logic        bus_ready,
  input  logic [31:0] bus_read_data,
  input  logic        bus_error
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  localparam logic [COUNTER_WIDTH:0]   TIMEOUT_LIMIT = TIMEOUT_CYCLES[COUNTER_WIDTH:0];
  localparam logic [COUNTER_WIDTH-1:0] COUNT_ONE     = {{(COUNTER_WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]               state;
  logic [COUNTER_WIDTH-1:0] wait_count;
  logic [31:0]              addr_q;
  logic [31:0]              wdata_q;
  logic [31:0]              rdata_q;
  logic [3:0]               be_q;
  logic                     write_q;
  logic                     fault_q;
  logic [3:0]               mask_be;
  logic [COUNTER_WIDTH:0]   count_next_ext;
  logic                     timeout_hit;

  always_comb begin
    mask_be = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      mask_be[i] = |write_memory_mask[8*i +: 8];
    end
  end

  // The cycle that would bring the count up to the limit is the last one granted.
  assign count_next_ext = {1'b0, wait_count} + {1'b0, COUNT_ONE};
  assign timeout_hit    = (TIMEOUT_CYCLES != 0) && !bus_ready && (count_next_ext >= TIMEOUT_LIMIT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      wait_count <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      be_q       <= '0;
      write_q    <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          wait_count <= '0;
          if (write_request) begin
            addr_q  <= write_memory_address & ~32'h3;
            wdata_q <= write_memory_data;
            be_q    <= mask_be;
            write_q <= 1'b1;
            state   <= ACCESS;
          end else if (read_request) begin
            addr_q  <= read_memory_address & ~32'h3;
            be_q    <= 4'hF;
            write_q <= 1'b0;
            state   <= ACCESS;
          end
        end
        ACCESS: begin
          if (bus_ready) begin
            fault_q <= bus_error;
            if (!bus_error && !write_q) begin
              rdata_q <= bus_read_data;
            end
            state <= DONE;
          end else begin
            if (!(&wait_count)) begin
              wait_count <= wait_count + COUNT_ONE;
            end
            if (timeout_hit) begin
              fault_q <= 1'b1;
              state   <= DONE;
            end
          end
        end
        DONE: begin
          wait_count <= '0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign read_memory_data = rdata_q;
  assign memory_busy      = (state != IDLE);
  assign memory_done      = (state == DONE);
  assign access_fault     = (state == DONE) && fault_q;
  assign bus_valid        = (state == ACCESS);
  assign bus_write        = write_q;
  assign bus_address      = addr_q;
  assign bus_write_data   = wdata_q;
  assign bus_byte_enable  = be_q;

endmodule

// File: tb/tb_memory_bridge.sv
// Randomized transactions against a transaction-level expectation of memory_bridge, plus directed cases.
module tb_memory_bridge;
  localparam int T = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        read_request, write_request;
  logic [31:0] read_memory_address, write_memory_address, write_memory_data, write_memory_mask;
  logic [31:0] read_memory_data;
  logic        memory_busy, memory_done, access_fault;
  logic        bus_valid, bus_write;
  logic [31:0] bus_address, bus_write_data;
  logic [3:0]  bus_byte_enable;
  logic        bus_ready, bus_error;
  logic [31:0] bus_read_data;

  logic        nt_read_request;
  logic [31:0] nt_read_data, nt_bus_address, nt_bus_write_data, nt_bus_read_data;
  logic        nt_busy, nt_done, nt_fault, nt_valid, nt_write, nt_bus_ready;
  logic [3:0]  nt_be;

  memory_bridge #(.TIMEOUT_CYCLES(T), .COUNTER_WIDTH(8)) dut (
    .clk(clk), .reset(rst_n),
    .read_request(read_request), .write_request(write_request),
    .read_memory_address(read_memory_address), .write_memory_address(write_memory_address),
    .write_memory_data(write_memory_data), .write_memory_mask(write_memory_mask),
    .read_memory_data(read_memory_data), .memory_busy(memory_busy), .memory_done(memory_done),
    .access_fault(access_fault), .bus_valid(bus_valid), .bus_write(bus_write),
    .bus_address(bus_address), .bus_write_data(bus_write_data), .bus_byte_enable(bus_byte_enable),
    .bus_ready(bus_ready), .bus_read_data(bus_read_data), .bus_error(bus_error)
  );

  memory_bridge #(.TIMEOUT_CYCLES(0), .COUNTER_WIDTH(8)) dut_nt (
    .clk(clk), .reset(rst_n),
    .read_request(nt_read_request), .write_request(1'b0),
    .read_memory_address(32'h0000_0300), .write_memory_address(32'h0),
    .write_memory_data(32'h0), .write_memory_mask(32'h0),
    .read_memory_data(nt_read_data), .memory_busy(nt_busy), .memory_done(nt_done),
    .access_fault(nt_fault), .bus_valid(nt_valid), .bus_write(nt_write),
    .bus_address(nt_bus_address), .bus_write_data(nt_bus_write_data), .bus_byte_enable(nt_be),
    .bus_ready(nt_bus_ready), .bus_read_data(nt_bus_read_data), .bus_error(1'b0)
  );

  // Expected view of the main bridge, maintained by the stimulus thread.
  logic        exp_valid, exp_busy, exp_done, exp_fault, exp_write;
  logic [31:0] exp_addr, exp_wdata, exp_rdata;
  logic [3:0]  exp_be;
  bit          chk_en = 1'b0;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          done_cyc = 0;
  int          done_count = 0;
  logic        last_fault = 1'b0;
  logic        last_write = 1'b0;
  logic [31:0] last_addr = '0;
  logic [3:0]  last_be = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] be_of(input logic [31:0] mask);
    logic [3:0] be;
    for (int i = 0; i < 4; i++) be[i] = (mask[8*i +: 8] != 8'h00);
    return be;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("bus_valid", {31'b0, bus_valid}, {31'b0, exp_valid});
      chk("memory_busy", {31'b0, memory_busy}, {31'b0, exp_busy});
      chk("memory_done", {31'b0, memory_done}, {31'b0, exp_done});
      chk("access_fault", {31'b0, access_fault}, {31'b0, exp_fault});
      chk("read_memory_data", read_memory_data, exp_rdata);
      if (exp_valid) begin
        chk("bus_address", bus_address, exp_addr);
        chk("bus_byte_enable", {28'b0, bus_byte_enable}, {28'b0, exp_be});
        chk("bus_write", {31'b0, bus_write}, {31'b0, exp_write});
        if (exp_write) chk("bus_write_data", bus_write_data, exp_wdata);
      end
    end
    if (bus_valid) begin
      last_addr  = bus_address;
      last_be    = bus_byte_enable;
      last_write = bus_write;
    end
    if (memory_done) begin
      done_cyc   = cyc;
      done_count++;
      last_fault = access_fault;
    end
  end

  // Called just after a rising edge with the bridge idle; returns with it idle again.
  task automatic txn(input bit rd, input bit wr, input logic [31:0] raddr, input logic [31:0] waddr,
                     input logic [31:0] wdata, input logic [31:0] mask, input int waits, input bit err,
                     input logic [31:0] rdat, output int strobe_cyc);
    bit is_wr;
    bit flt;
    int acc;
    is_wr = wr;
    read_request = rd; write_request = wr;
    read_memory_address = raddr; write_memory_address = waddr;
    write_memory_data = wdata; write_memory_mask = mask;
    exp_valid = 0; exp_busy = 0; exp_done = 0; exp_fault = 0;
    exp_write = is_wr;
    exp_addr  = (is_wr ? waddr : raddr) & ~32'h3;
    exp_be    = is_wr ? be_of(mask) : 4'hF;
    exp_wdata = wdata;
    flt = (waits >= T) ? 1'b1 : err;
    acc = (waits >= T) ? T : waits + 1;
    strobe_cyc = cyc;
    for (int k = 0; k < acc; k++) begin
      @(posedge clk); #1;
      read_request = $urandom_range(0, 1); write_request = $urandom_range(0, 1);
      read_memory_address = $urandom; write_memory_address = $urandom;
      write_memory_data = $urandom; write_memory_mask = $urandom;
      exp_valid = 1; exp_busy = 1;
      bus_ready     = (k == waits);
      bus_error     = (k == waits) ? err : 1'($urandom);
      bus_read_data = (k == waits) ? rdat : $urandom;
    end
    @(posedge clk); #1;
    bus_ready = 0; bus_error = $urandom_range(0, 1);
    read_request = $urandom_range(0, 1); write_request = $urandom_range(0, 1);
    exp_valid = 0; exp_done = 1; exp_fault = flt;
    if (!is_wr && !flt) exp_rdata = rdat;
    @(posedge clk); #1;
    read_request = 0; write_request = 0;
    exp_done = 0; exp_busy = 0; exp_fault = 0;
  endtask

  function automatic logic [31:0] rand_mask();
    logic [31:0] m;
    for (int i = 0; i < 4; i++) begin
      case ($urandom_range(0, 2))
        0:       m[8*i +: 8] = 8'h00;
        1:       m[8*i +: 8] = 8'hFF;
        default: m[8*i +: 8] = 8'($urandom);
      endcase
    end
    return m;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int sc;
    int dc0;
    rst_n = 0;
    read_request = 0; write_request = 0;
    read_memory_address = 0; write_memory_address = 0; write_memory_data = 0; write_memory_mask = 0;
    bus_ready = 0; bus_error = 0; bus_read_data = 0;
    nt_read_request = 0; nt_bus_ready = 0; nt_bus_read_data = 0;
    exp_valid = 0; exp_busy = 0; exp_done = 0; exp_fault = 0; exp_write = 0;
    exp_addr = 0; exp_wdata = 0; exp_rdata = 0; exp_be = 0;
    #2;
    chk("rst_valid", {31'b0, bus_valid}, 32'd0);
    chk("rst_busy", {31'b0, memory_busy}, 32'd0);
    chk("rst_done", {31'b0, memory_done}, 32'd0);
    chk("rst_rdata", read_memory_data, 32'd0);
    chk("rst_address", bus_address, 32'd0);
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    chk_en = 1;

    txn(1, 0, 32'h0000_0104, 32'h0, 32'h0, 32'h0, 0, 0, 32'hDEAD_BEEF, sc);
    chk("rd0_latency", done_cyc - sc, 32'd2);
    chk("rd0_address", last_addr, 32'h0000_0104);
    chk("rd0_be", {28'b0, last_be}, 32'hF);
    chk("rd0_data", read_memory_data, 32'hDEAD_BEEF);
    chk("rd0_fault", {31'b0, last_fault}, 32'd0);

    txn(0, 1, 32'h0, 32'h0000_0203, 32'hAB00_0000, 32'hFF00_0000, 3, 0, 32'h0, sc);
    chk("st_latency", done_cyc - sc, 32'd5);
    chk("st_address", last_addr, 32'h0000_0200);
    chk("st_be", {28'b0, last_be}, 32'h8);
    chk("st_write", {31'b0, last_write}, 32'd1);

    dc0 = done_count;
    txn(1, 1, 32'h0000_0400, 32'h0000_0500, 32'h1111_2222, 32'hFFFF_FFFF, 1, 0, 32'h0, sc);
    chk("both_write", {31'b0, last_write}, 32'd1);
    chk("both_address", last_addr, 32'h0000_0500);
    chk("both_done_count", done_count - dc0, 32'd1);

    txn(1, 0, 32'h0000_0010, 32'h0, 32'h0, 32'h0, 0, 0, 32'h1234_5678, sc);
    txn(1, 0, 32'h0000_0014, 32'h0, 32'h0, 32'h0, 2, 1, 32'hFFFF_0000, sc);
    chk("err_fault", {31'b0, last_fault}, 32'd1);
    chk("err_rdata", read_memory_data, 32'h1234_5678);

    txn(1, 0, 32'h0000_0020, 32'h0, 32'h0, 32'h0, 10, 0, 32'h0, sc);
    chk("to_latency", done_cyc - sc, 32'd5);
    chk("to_fault", {31'b0, last_fault}, 32'd1);
    chk("to_rdata", read_memory_data, 32'h1234_5678);

    for (int n = 0; n < 200; n++) begin
      int kind;
      kind = $urandom_range(0, 2);
      txn(kind != 1, kind != 0, $urandom, $urandom, $urandom, rand_mask(),
          $urandom_range(0, 5), ($urandom_range(0, 3) == 0), $urandom, sc);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end

    // No-timeout instance: 100 wait states must not abort.
    nt_read_request = 1;
    @(posedge clk); #1; nt_read_request = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      chk("nt_valid", {31'b0, nt_valid}, 32'd1);
      chk("nt_no_done", {31'b0, nt_done}, 32'd0);
    end
    @(posedge clk); #1; nt_bus_ready = 1; nt_bus_read_data = 32'h55AA_33CC;
    @(posedge clk); #1; nt_bus_ready = 0;
    @(negedge clk);
    chk("nt_done", {31'b0, nt_done}, 32'd1);
    chk("nt_fault", {31'b0, nt_fault}, 32'd0);
    chk("nt_rdata", nt_read_data, 32'h55AA_33CC);
    @(posedge clk); #1;

    // Asynchronous reset in the middle of an access.
    chk_en = 0;
    read_request = 1; read_memory_address = 32'h0000_0900; bus_ready = 0;
    @(posedge clk); #1; read_request = 0;
    @(posedge clk); #3;
    chk("pre_rst_valid", {31'b0, bus_valid}, 32'd1);
    rst_n = 0;
    #1;
    chk("mid_rst_valid", {31'b0, bus_valid}, 32'd0);
    chk("mid_rst_busy", {31'b0, memory_busy}, 32'd0);
    chk("mid_rst_rdata", read_memory_data, 32'd0);
    dc0 = done_count;
    @(posedge clk); #2; rst_n = 1;
    @(posedge clk); #1;
    exp_valid = 0; exp_busy = 0; exp_done = 0; exp_fault = 0; exp_rdata = 0;
    chk_en = 1;
    txn(1, 0, 32'h0000_0A00, 32'h0, 32'h0, 32'h0, 1, 0, 32'hCAFE_F00D, sc);
    chk("post_rst_latency", done_cyc - sc, 32'd3);
    chk("post_rst_data", read_memory_data, 32'hCAFE_F00D);
    chk("post_rst_done_count", done_count - dc0, 32'd1);

    @(posedge clk); #1;
    chk_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
